// File: rtl/stats_readout_ctrl.sv
// Snapshots the run-statistics counters on a trigger and streams them out over valid/ready.
// Optional fifth "missed conditional branches" word enabled by STATS_MISS_WORD_EN.
module stats_readout_ctrl #(
    parameter int unsigned GAP         = 2,
    parameter int unsigned AUTO_REPEAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        snap_req,
    input  logic [31:0] cnt_total,
    input  logic [31:0] cnt_cond,
    input  logic [31:0] cnt_uncond,
    input  logic [31:0] cnt_cond_ok,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {StIdle, StCapture, StSend, StGap, StDone} state_e;

`ifdef STATS_MISS_WORD_EN
    localparam logic [2:0] LastIdx = 3'd4;
`else
    localparam logic [2:0] LastIdx = 3'd3;
`endif

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            halt_q;
    logic [31:0]     snap_total_q, snap_cond_q, snap_uncond_q, snap_cond_ok_q;
    logic            trigger;
    logic [31:0]     word;

    assign trigger = (halt & ~halt_q) | snap_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            idx_q          <= 3'd0;
            gap_q          <= '0;
            halt_q         <= 1'b0;
            snap_total_q   <= 32'd0;
            snap_cond_q    <= 32'd0;
            snap_uncond_q  <= 32'd0;
            snap_cond_ok_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            halt_q  <= halt;
            if (state_q == StCapture) begin
                snap_total_q   <= cnt_total;
                snap_cond_q    <= cnt_cond;
                snap_uncond_q  <= cnt_uncond;
                snap_cond_ok_q <= cnt_cond_ok;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StCapture;
            end
            StCapture: begin
                idx_d   = 3'd0;
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        if (GAP > 0) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) state_d = StSend;
                else                  gap_d   = gap_q + 1'b1;
            end
            StDone: begin
                state_d = ((AUTO_REPEAT != 0) && halt) ? StCapture : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        word = 32'd0;
        case (idx_q)
            3'd0: word = snap_total_q;
            3'd1: word = snap_cond_q;
            3'd2: word = snap_uncond_q;
            3'd3: word = snap_cond_ok_q;
`ifdef STATS_MISS_WORD_EN
            // Saturates so a counter glitch never shows as a huge miss count.
            3'd4: word = (snap_cond_q > snap_cond_ok_q) ? snap_cond_q - snap_cond_ok_q : 32'd0;
`endif
            default: word = 32'd0;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StSend);
        out_data  = out_valid ? word : 32'd0;
        out_idx   = out_valid ? idx_q : 3'd0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

endmodule

// File: tb/tb_stats_readout_ctrl.sv
// Directed bench for stats_readout_ctrl: per-cycle vector table plus hand-written sequences.
// Define STATS_MISS_WORD_EN to also check the fifth (miss) word.
module tb_stats_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        snap_req;
    logic [31:0] cnt_total, cnt_cond, cnt_uncond, cnt_cond_ok;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

`ifdef STATS_MISS_WORD_EN
    localparam int NumWords = 5;
`else
    localparam int NumWords = 4;
`endif

    stats_readout_ctrl #(.GAP(2), .AUTO_REPEAT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .snap_req   (snap_req),
        .cnt_total  (cnt_total),
        .cnt_cond   (cnt_cond),
        .cnt_uncond (cnt_uncond),
        .cnt_cond_ok(cnt_cond_ok),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        snap_req;
        logic        out_ready;
        logic        valid;
        logic [31:0] data;
        logic [2:0]  idx;
        logic        busy;
        logic        done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] miss(input logic [31:0] c, input logic [31:0] ok);
        return (c > ok) ? c - ok : 32'd0;
    endfunction

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    // Collects words with out_ready high until done, starting from word index 'first'.
    task automatic collect(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4, input int first,
                           input bit poke, input bit chg, input string tag);
        logic [31:0] exp_w [5];
        int got, dn, cyc, extra;
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3; exp_w[4] = e4;
        got = first; dn = 0; cyc = 0; extra = 0;
        out_ready = 1'b1;
        while (dn == 0 && cyc < 200) begin
            tick();
            cyc++;
            if (out_valid) begin
                if (got < 5) begin
                    check({tag, "_data"}, out_data, exp_w[got]);
                    check({tag, "_idx"}, {29'd0, out_idx}, got[31:0]);
                end
                got++;
                if (chg) cnt_total = 32'd999;
            end
            if (done) dn++;
            snap_req = poke && !done && cyc[0];
        end
        snap_req = 1'b0;
        check({tag, "_words"}, got[31:0], NumWords);
        check({tag, "_done_seen"}, dn[31:0], 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) extra++;
        end
        check({tag, "_quiet_after"}, extra[31:0], 0);
    endtask

    vec_t vecs [14];

    initial begin
        int n;
        // Trigger at vector 0; SEND words appear after vectors 1,4,7,10; DONE after 11.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'd100, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'd20,  3'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'd7,   3'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'd15,  3'd3, 1'b1, 1'b0};
`ifdef STATS_MISS_WORD_EN
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd5,   3'd4, 1'b1, 1'b0};
`else
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd0,   3'd0, 1'b0, 1'b0};
`endif

        rst = 1'b1; halt = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
        cnt_total = 32'd100; cnt_cond = 32'd20; cnt_uncond = 32'd7; cnt_cond_ok = 32'd15;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", {29'd0, out_idx}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 0);

        // 1: table-driven stream with GAP=2
        for (int i = 0; i < 14; i++) begin
            snap_req  = vecs[i].snap_req;
            out_ready = vecs[i].out_ready;
            tick();
            check($sformatf("t1_v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
            check($sformatf("t1_v%0d_data", i), out_data, vecs[i].data);
            check($sformatf("t1_v%0d_idx", i), {29'd0, out_idx}, {29'd0, vecs[i].idx});
            check($sformatf("t1_v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("t1_v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
        end
        snap_req = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("t1_idle_after", {31'd0, busy}, 0);

        // 2: halt edge trigger; total changed during SEND must not leak into the stream
        halt = 1'b1;
        tick();
        collect(100, 20, 7, 15, miss(20, 15), 0, 1'b0, 1'b1, "t2");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) n++;
        end
        check("t2_no_rerun", n[31:0], 0);
        halt = 1'b0;
        cnt_total = 32'd100;
        tick();

        // 3: backpressure at idx1
        out_ready = 1'b0;
        pulse_snap();
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("t3_w0_data", out_data, 100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", {31'd0, out_valid}, 1);
            check("t3_hold_data", out_data, 20);
            check("t3_hold_idx", {29'd0, out_idx}, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t3_advance_valid", {31'd0, out_valid}, 0);
        collect(100, 20, 7, 15, miss(20, 15), 2, 1'b0, 1'b0, "t3");

        // 4: snap_req pokes during SEND/GAP are dropped
        pulse_snap();
        collect(100, 20, 7, 15, miss(20, 15), 0, 1'b1, 1'b0, "t4");

        // 5: reset mid-transfer at idx2, then a fresh snapshot
        out_ready = 1'b1;
        pulse_snap();
        n = 0;
        while (!(out_valid && out_idx == 3'd2) && n < 30) begin tick(); n++; end
        check("t5_reached_idx2", {29'd0, out_idx}, 2);
        #2 rst = 1'b1;
        #1;
        check("t5_abort_valid", {31'd0, out_valid}, 0);
        check("t5_abort_busy", {31'd0, busy}, 0);
        check("t5_abort_done", {31'd0, done}, 0);
        check("t5_abort_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_total = 32'd11; cnt_cond = 32'd22; cnt_uncond = 32'd33; cnt_cond_ok = 32'd44;
        tick();
        pulse_snap();
        collect(11, 22, 33, 44, miss(22, 44), 0, 1'b0, 1'b0, "t5");

        // 6: saturating miss word (cond < cond_ok)
        cnt_total = 32'd50; cnt_cond = 32'd3; cnt_uncond = 32'd9; cnt_cond_ok = 32'd5;
        pulse_snap();
        collect(50, 3, 9, 5, miss(3, 5), 0, 1'b0, 1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
